// File: rtl/fma_issue_scheduler_pkg.sv
// Shared constants and types for the FMA issue scheduler: default datapath
// geometry, FSM encodings and the requester-ID width helper.
package fma_issue_scheduler_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_SIG_WIDTH = 23;
    localparam int DEF_EXP_WIDTH = 8;
    localparam int DEF_PIPE_LAT  = 3;
    localparam int DEF_W         = 1 + DEF_EXP_WIDTH + DEF_SIG_WIDTH;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // A single requester still needs a one-bit ID field.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fma_issue_scheduler_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above ptr,
// wrapping from NUM_REQ-1 back to 0. The pointer register lives in the caller.
module rr_arbiter
    import fma_issue_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx
);

    localparam logic [IDW:0] N = (IDW + 1)'(NUM_REQ);

    logic [IDW:0] cand;
    logic         found;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path leaves one unassigned (no latch).
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDW + 1)'(i);
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
        grant[idx] = found;
    end

endmodule

// File: rtl/fma_issue_scheduler.sv
// Shares one fixed-latency FMA datapath among NUM_REQ requesters; a tag pipe
// matched to the datapath latency steers each result back to its issuer.
module fma_issue_scheduler
    import fma_issue_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int SIG_WIDTH = DEF_SIG_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int PIPE_LAT  = DEF_PIPE_LAT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ*(1+EXP_WIDTH+SIG_WIDTH)-1:0] req_a,
    input  logic [NUM_REQ*(1+EXP_WIDTH+SIG_WIDTH)-1:0] req_b,
    input  logic [NUM_REQ*(1+EXP_WIDTH+SIG_WIDTH)-1:0] req_c,
    output logic                                     dp_valid,
    output logic [EXP_WIDTH+SIG_WIDTH:0]             dp_a,
    output logic [EXP_WIDTH+SIG_WIDTH:0]             dp_b,
    output logic [EXP_WIDTH+SIG_WIDTH:0]             dp_c,
    input  logic [EXP_WIDTH+SIG_WIDTH:0]             dp_res,
    output logic [NUM_REQ-1:0]                       rsp_valid,
    output logic [EXP_WIDTH+SIG_WIDTH:0]             rsp_data,
    input  logic                                     halt_req,
    output logic                                     halted,
    output logic [15:0]                              issue_cnt
);

    localparam int W   = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int IDW = id_width(NUM_REQ);
    localparam int CW  = $clog2(PIPE_LAT + 2);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               handshake;
    logic [IDW-1:0]     issue_id;
    tag_t               tag_pipe [PIPE_LAT];
    tag_t               tag_out;
    logic [CW-1:0]      inflight;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Halt masks the grant in the very cycle it is first seen.
    assign req_ready = (state == RUN && !halt_req) ? grant : '0;
    assign handshake = |(req_ready & req_valid);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            ptr       <= '0;
            dp_valid  <= 1'b0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_c      <= '0;
            issue_id  <= '0;
            issue_cnt <= '0;
        end else begin
            dp_valid <= handshake;
            if (handshake) begin
                ptr       <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
                dp_a      <= req_a[int'(grant_idx)*W +: W];
                dp_b      <= req_b[int'(grant_idx)*W +: W];
                dp_c      <= req_c[int'(grant_idx)*W +: W];
                issue_id  <= grant_idx;
                issue_cnt <= issue_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the tag pipe is reset, unlike a data array, since stale valid bits would strobe results after reset.
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: dp_valid, id: issue_id};
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out = tag_pipe[PIPE_LAT-1];

    always_comb begin
        rsp_valid = '0;
        if (tag_out.valid) begin
            rsp_valid[tag_out.id] = 1'b1;
        end
    end

    assign rsp_data = dp_res;

    // Counts the issue register plus the tag pipe, so it tops out at PIPE_LAT+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({handshake, tag_out.valid})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!halt_req) begin
                        state <= RUN;
                    end else if (inflight == '0) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fma_issue_scheduler.sv
// Directed bench for fma_issue_scheduler: a behavioural FMA pipe drives dp_res,
// expected results are queued at issue and popped by an independent monitor.
module tb_fma_issue_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int SIG_WIDTH = 23;
    localparam int EXP_WIDTH = 8;
    localparam int PIPE_LAT  = 3;
    localparam int W         = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*W-1:0]   req_a, req_b, req_c;
    logic                   dp_valid;
    logic [W-1:0]           dp_a, dp_b, dp_c, dp_res;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [W-1:0]           rsp_data;
    logic                   halt_req;
    logic                   halted;
    logic [15:0]            issue_cnt;

    fma_issue_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .SIG_WIDTH (SIG_WIDTH),
        .EXP_WIDTH (EXP_WIDTH),
        .PIPE_LAT  (PIPE_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .dp_valid  (dp_valid),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_c      (dp_c),
        .dp_res    (dp_res),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .halt_req  (halt_req),
        .halted    (halted),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] exp_res [NUM_REQ];
    logic [31:0] st [PIPE_LAT];
    logic        last_hs = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single-precision <-> real for normal numbers (exact for the vectors used).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural datapath: exact fma, PIPE_LAT cycles from dp_valid to dp_res.
    always @(posedge clk) begin
        st[0] <= dp_valid ? r2f(f2r(dp_a) * f2r(dp_b) + f2r(dp_c)) : 32'hDEADBEEF;
        for (int i = 1; i < PIPE_LAT; i++) st[i] <= st[i-1];
    end
    assign dp_res = st[PIPE_LAT-1];

    // Monitor: pops the oldest expectation whenever a result is due or shows up.
    always @(negedge clk) begin
        if (rsp_valid != '0 || (sb.size() > 0 && sb[0].due <= cyc)) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
                check("rsp_valid", 64'(rsp_valid), 64'(1) << mon_e.id);
                check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
            end
        end
    end

    task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] res);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_c[r*W +: W] = c;
        exp_res[r]      = res;
    endtask

    task automatic tick(input logic [NUM_REQ-1:0] exp_ready, input logic exp_halted, input string name);
        @(negedge clk);
        check({name, "/ready"}, 64'(req_ready), 64'(exp_ready));
        check({name, "/halted"}, 64'(halted), 64'(exp_halted));
        check({name, "/dp_valid"}, 64'(dp_valid), 64'(last_hs));
        last_hs = |exp_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_ready[i]) sb.push_back('{id: i, data: exp_res[i], due: cyc + 1 + PIPE_LAT});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b0, "idle");
    endtask

    task automatic do_reset(input logic expect_drained);
        if (expect_drained) check("drained", 64'(sb.size()), 64'd0);
        req_valid = '0;
        halt_req  = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        sb.delete();
        last_hs = 1'b0;
        @(negedge clk);
        check("rst/issue_cnt", 64'(issue_cnt), 64'd0);
        check("rst/rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst/dp_valid", 64'(dp_valid), 64'd0);
        check("rst/halted", 64'(halted), 64'd0);
        check("rst/dp_a", 64'(dp_a), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0] g;
        req_valid = '0;
        halt_req  = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        set_ops(0, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h40D00000); // 2*3+0.5  = 6.5
        set_ops(1, 32'h40800000, 32'h3E800000, 32'h41200000, 32'h41300000); // 4*0.25+10 = 11
        set_ops(2, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000); // 1*2+1    = 3
        set_ops(3, 32'hC0000000, 32'h40A00000, 32'h3F800000, 32'hC1100000); // -2*5+1   = -9
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        // Single op from requester 2.
        idle(3);
        req_valid = 4'b0100;
        tick(4'b0100, 1'b0, "single");
        req_valid = '0;
        tick('0, 1'b0, "single_issue");
        check("single/dp_a", 64'(dp_a), 64'h3F800000);
        check("single/dp_b", 64'(dp_b), 64'h40000000);
        check("single/dp_c", 64'(dp_c), 64'h3F800000);
        idle(6);
        check("single/issue_cnt", 64'(issue_cnt), 64'd1);

        // All requesters valid: strict rotation.
        do_reset(1'b1);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            g = 4'b0001 << (k % 4);
            tick(g, 1'b0, "rotate");
        end
        req_valid = '0;
        idle(6);
        check("rotate/issue_cnt", 64'(issue_cnt), 64'd8);

        // Fairness between 1 and 3 with the pointer moved to 2.
        do_reset(1'b1);
        req_valid = 4'b0010;
        tick(4'b0010, 1'b0, "fair_setup");
        req_valid = 4'b1010;
        tick(4'b1000, 1'b0, "fair");
        tick(4'b0010, 1'b0, "fair");
        tick(4'b1000, 1'b0, "fair");
        tick(4'b0010, 1'b0, "fair");
        req_valid = '0;
        idle(6);

        // Halt with three ops in flight, then release.
        do_reset(1'b1);
        req_valid = '1;
        tick(4'b0001, 1'b0, "pre_halt");
        tick(4'b0010, 1'b0, "pre_halt");
        tick(4'b0100, 1'b0, "pre_halt");
        halt_req = 1'b1;
        for (int t = 0; t < 7; t++) tick('0, (t >= 5), "halt");
        halt_req = 1'b0;
        tick('0, 1'b1, "unhalt");
        tick(4'b1000, 1'b0, "resume");
        req_valid = '0;
        idle(6);

        // One-cycle halt pulse during drain: back to RUN, nothing lost.
        do_reset(1'b1);
        req_valid = '1;
        tick(4'b0001, 1'b0, "pulse_pre");
        tick(4'b0010, 1'b0, "pulse_pre");
        req_valid = '0;
        halt_req  = 1'b1;
        tick('0, 1'b0, "pulse");
        halt_req  = 1'b0;
        req_valid = '1;
        tick('0, 1'b0, "pulse_drain");
        tick(4'b0100, 1'b0, "pulse_resume");
        req_valid = '0;
        for (int t = 0; t < 6; t++) tick('0, 1'b0, "pulse_after");

        // Reset with two ops in flight: their results must never be strobed.
        do_reset(1'b1);
        req_valid = '1;
        tick(4'b0001, 1'b0, "rst_pre");
        tick(4'b0010, 1'b0, "rst_pre");
        req_valid = '0;
        tick('0, 1'b0, "rst_pre");
        do_reset(1'b0);
        idle(6);
        req_valid = '1;
        tick(4'b0001, 1'b0, "rst_ptr");
        req_valid = '0;
        idle(6);
        check("final/drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
